// File: rtl/m_store_queue_if.sv
// Store-queue bus: core store inputs, memory drain handshake and queue status.
// master = core/memory side, slave = the store queue itself.
interface m_store_queue_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [1:0]    st_sel;
  logic [31:0]   st_addr;
  logic [31:0]   st_wdata;
  logic          st_ov;
  logic          st_ready;
  logic          ades;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_byteen;
  logic          mem_ack;
  logic [CW-1:0] sq_count;
  logic          sq_empty;

  modport master (
    output st_valid, st_sel, st_addr, st_wdata, st_ov, mem_ack,
    input  st_ready, ades, mem_req, mem_addr, mem_wdata, mem_byteen, sq_count, sq_empty
  );

  modport slave (
    input  st_valid, st_sel, st_addr, st_wdata, st_ov, mem_ack,
    output st_ready, ades, mem_req, mem_addr, mem_wdata, mem_byteen, sq_count, sq_empty
  );
endinterface

// File: rtl/m_store_queue.sv
// M-stage store unit: AdES check, lane alignment, DEPTH-entry FIFO draining over req/ack.
// Optional tail-entry write merging is built only when STQ_MERGE_EN is defined.
module m_store_queue_lane #(parameter int LANE = 0) (
  input  logic [1:0]  sel,
  input  logic [1:0]  boff,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  data
);
  localparam logic [1:0] LID = 2'(LANE);

  always_comb begin
    be   = 1'b0;
    data = 8'h00;
    case (sel)
      2'b00: begin be = 1'b1;              data = wdata[8*LANE +: 8]; end
      2'b01: begin be = (boff[1] == LID[1]); data = LID[0] ? wdata[15:8] : wdata[7:0]; end
      2'b10: begin be = (boff == LID);     data = wdata[7:0]; end
      default: ;
    endcase
  end
endmodule

module m_store_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] DM_TOP    = 32'h2fff,
  parameter logic [31:0] TMR0_BASE = 32'h7f00,
  parameter logic [31:0] TMR1_BASE = 32'h7f10,
  parameter logic [31:0] INT_BASE  = 32'h7f20
) (
  input logic           clk,
  input logic           rst_n,
  m_store_queue_if.slave sq
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;

  typedef struct packed {
    logic [29:0]                 waddr;
    logic [NUM_LANES-1:0][7:0]   data;
    logic [NUM_LANES-1:0]        be;
  } sq_ent_t;

  sq_ent_t       ent_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic [31:0] a;
  logic        st, is_sw, is_sh, is_sb;
  logic        in_dm, in_t0, in_t1, in_int, cnt0, cnt1, bad, st_ok;
  logic        not_full, merge_hit, push, pop, req;
  logic [NUM_LANES-1:0]      new_be;
  logic [NUM_LANES-1:0][7:0] new_data;
  sq_ent_t     head;

  assign a     = sq.st_addr;
  assign st    = sq.st_valid && (sq.st_sel != 2'b11);
  assign is_sw = (sq.st_sel == 2'b00);
  assign is_sh = (sq.st_sel == 2'b01);
  assign is_sb = (sq.st_sel == 2'b10);

  assign in_dm  = (a <= DM_TOP);
  assign in_t0  = (a >= TMR0_BASE) && (a <= TMR0_BASE + 32'd11);
  assign in_t1  = (a >= TMR1_BASE) && (a <= TMR1_BASE + 32'd11);
  assign in_int = (a >= INT_BASE)  && (a <= INT_BASE + 32'd3);
  assign cnt0   = (a >= TMR0_BASE + 32'd8) && (a <= TMR0_BASE + 32'd11);
  assign cnt1   = (a >= TMR1_BASE + 32'd8) && (a <= TMR1_BASE + 32'd11);

  assign bad = (is_sw && (a[1:0] != 2'b00)) || (is_sh && a[0])
            || ((is_sh || is_sb) && (in_t0 || in_t1)) || cnt0 || cnt1 || sq.st_ov
            || !(in_dm || in_t0 || in_t1 || in_int);
  assign sq.ades = st && bad;
  assign st_ok   = st && !bad;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    m_store_queue_lane #(.LANE(i)) u_lane (
      .sel   (sq.st_sel),
      .boff  (a[1:0]),
      .wdata (sq.st_wdata),
      .be    (new_be[i]),
      .data  (new_data[i])
    );
  end

`ifdef STQ_MERGE_EN
  logic [AW-1:0] tail_m1;
  assign tail_m1 = tail_q - 1'b1;
  // Tail must not be the head, otherwise the bytes could change under an in-flight request.
  assign merge_hit = st_ok && (count_q >= CW'(2)) && in_dm
                  && (ent_q[tail_m1].waddr == a[31:2]);
`else
  assign merge_hit = 1'b0;
`endif

  assign not_full    = (count_q < CW'(DEPTH));
  assign sq.st_ready = not_full || merge_hit;
  assign push        = st_ok && !merge_hit && not_full;
  assign req         = (count_q != '0);
  assign pop         = req && sq.mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Payload needs no reset: outputs are gated by mem_req, which is count-based.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_q[tail_q].waddr <= a[31:2];
      ent_q[tail_q].data  <= new_data;
      ent_q[tail_q].be    <= new_be;
    end
`ifdef STQ_MERGE_EN
    else if (merge_hit) begin
      ent_q[tail_m1].be <= ent_q[tail_m1].be | new_be;
      for (int i = 0; i < NUM_LANES; i++)
        if (new_be[i]) ent_q[tail_m1].data[i] <= new_data[i];
    end
`endif
  end

  assign head          = ent_q[head_q];
  assign sq.mem_req    = req;
  assign sq.mem_addr   = req ? {head.waddr, 2'b00} : 32'h0;
  assign sq.mem_wdata  = req ? head.data : 32'h0;
  assign sq.mem_byteen = req ? head.be : 4'h0;
  assign sq.sq_count   = count_q;
  assign sq.sq_empty   = (count_q == '0);
endmodule

// File: tb/tb_m_store_queue.sv
// Directed table-driven bench for m_store_queue plus hand-written reset-mid-drain sequence.
module tb_m_store_queue;
  localparam logic [1:0] SW = 2'b00, SH = 2'b01, SB = 2'b10, NO = 2'b11;
`ifdef STQ_MERGE_EN
  localparam bit M = 1'b1;
`else
  localparam bit M = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [31:0] addr, wd;
    logic        ov, ack;
    logic        ades, rdy;
    logic [2:0]  cnt;
    logic [31:0] maddr, mwd;
    logic [3:0]  be;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  m_store_queue_if #(.DEPTH(4)) sq();
  m_store_queue #(.DEPTH(4)) u_dut (.clk(clk), .rst_n(rst_n), .sq(sq));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] sel, input logic [31:0] addr,
                              input logic [31:0] wd, input logic ov, input logic ack,
                              input logic ades, input logic rdy, input logic [2:0] cnt,
                              input logic [31:0] maddr, input logic [31:0] mwd,
                              input logic [3:0] be);
    vec_t r;
    r.v = v; r.sel = sel; r.addr = addr; r.wd = wd; r.ov = ov; r.ack = ack;
    r.ades = ades; r.rdy = rdy; r.cnt = cnt; r.maddr = maddr; r.mwd = mwd; r.be = be;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] addr,
                       input logic [31:0] wd, input logic ov, input logic ack);
    sq.st_valid = v; sq.st_sel = sel; sq.st_addr = addr;
    sq.st_wdata = wd; sq.st_ov = ov; sq.mem_ack = ack;
  endtask

  initial begin
    drive(1'b0, NO, 32'h0, 32'h0, 1'b0, 1'b0);

    // sb lane 3, then drain it
    tbl.push_back(mk(1, SB, 32'h13, 32'hab, 0, 0, 0, 1, 1, 32'h10, 32'habababab, 4'b1000));
    tbl.push_back(mk(0, NO, 32'h0, 32'h0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 4'h0));
    // address exceptions: nothing enqueued, ack with empty queue ignored
    tbl.push_back(mk(1, SH, 32'h7f04, 32'h0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 4'h0));
    tbl.push_back(mk(1, SW, 32'h7f08, 32'h0, 0, 1, 1, 1, 0, 32'h0, 32'h0, 4'h0));
    tbl.push_back(mk(1, SW, 32'h3000, 32'h0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 4'h0));
    tbl.push_back(mk(1, SW, 32'h0002, 32'h0, 0, 1, 1, 1, 0, 32'h0, 32'h0, 4'h0));
    tbl.push_back(mk(1, SW, 32'h0004, 32'h0, 1, 0, 1, 1, 0, 32'h0, 32'h0, 4'h0));
    // fill to DEPTH with head held stable, one illegal sb in between, then a blocked fifth
    tbl.push_back(mk(1, SW, 32'h7f00, 32'h11111111, 0, 0, 0, 1, 1, 32'h7f00, 32'h11111111, 4'hf));
    tbl.push_back(mk(1, SW, 32'h7f20, 32'h22222222, 0, 0, 0, 1, 2, 32'h7f00, 32'h11111111, 4'hf));
    tbl.push_back(mk(1, SH, 32'h2ffe, 32'h00003344, 0, 0, 0, 1, 3, 32'h7f00, 32'h11111111, 4'hf));
    tbl.push_back(mk(1, SB, 32'h7f14, 32'h55, 0, 0, 1, 1, 3, 32'h7f00, 32'h11111111, 4'hf));
    tbl.push_back(mk(1, SB, 32'h0001, 32'h66, 0, 0, 0, 1, 4, 32'h7f00, 32'h11111111, 4'hf));
    tbl.push_back(mk(1, SW, 32'h0008, 32'h77777777, 0, 0, 0, 0, 4, 32'h7f00, 32'h11111111, 4'hf));
    // drain in FIFO order, one pop per cycle
    tbl.push_back(mk(0, NO, 32'h0, 32'h0, 0, 1, 0, 0, 3, 32'h7f20, 32'h22222222, 4'hf));
    tbl.push_back(mk(0, NO, 32'h0, 32'h0, 0, 1, 0, 1, 2, 32'h2ffc, 32'h33443344, 4'b1100));
    tbl.push_back(mk(0, NO, 32'h0, 32'h0, 0, 1, 0, 1, 1, 32'h0, 32'h66666666, 4'b0010));
    // push and pop together at count=1
    tbl.push_back(mk(1, SW, 32'h40, 32'h88888888, 0, 1, 0, 1, 1, 32'h40, 32'h88888888, 4'hf));
    tbl.push_back(mk(0, NO, 32'h0, 32'h0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 4'h0));
    // merge candidate: sb 0x21 then sb 0x22 with a different head in front
    tbl.push_back(mk(1, SW, 32'h100, 32'h01020304, 0, 0, 0, 1, 1, 32'h100, 32'h01020304, 4'hf));
    tbl.push_back(mk(1, SB, 32'h21, 32'h12, 0, 0, 0, 1, 2, 32'h100, 32'h01020304, 4'hf));
    tbl.push_back(mk(1, SB, 32'h22, 32'h34, 0, 0, 0, 1, M ? 3'd2 : 3'd3, 32'h100, 32'h01020304, 4'hf));
    tbl.push_back(mk(0, NO, 32'h0, 32'h0, 0, 1, 0, 1, M ? 3'd1 : 3'd2, 32'h20,
                     M ? 32'h12341212 : 32'h12121212, M ? 4'b0110 : 4'b0010));
    tbl.push_back(mk(0, NO, 32'h0, 32'h0, 0, 1, 0, 1, M ? 3'd0 : 3'd1, M ? 32'h0 : 32'h20,
                     M ? 32'h0 : 32'h34343434, M ? 4'h0 : 4'b0100));
    tbl.push_back(mk(0, NO, 32'h0, 32'h0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 4'h0));

    // reset state
    #12;
    chk("rst_req", sq.mem_req, 0);
    chk("rst_empty", sq.sq_empty, 1);
    chk("rst_ready", sq.st_ready, 1);
    chk("rst_count", sq.sq_count, 0);
    chk("rst_addr", sq.mem_addr, 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].sel, tbl[i].addr, tbl[i].wd, tbl[i].ov, tbl[i].ack);
      #1;
      chk($sformatf("v%0d_ades", i), sq.ades, tbl[i].ades);
      chk($sformatf("v%0d_ready", i), sq.st_ready, tbl[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_count", i), sq.sq_count, tbl[i].cnt);
      chk($sformatf("v%0d_empty", i), sq.sq_empty, tbl[i].cnt == 0);
      chk($sformatf("v%0d_req", i), sq.mem_req, tbl[i].cnt != 0);
      chk($sformatf("v%0d_addr", i), sq.mem_addr, tbl[i].maddr);
      chk($sformatf("v%0d_wdata", i), sq.mem_wdata, tbl[i].mwd);
      chk($sformatf("v%0d_byteen", i), sq.mem_byteen, tbl[i].be);
    end

    // async reset with three pending entries and an un-acked head
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, SW, 32'h200 + 32'(4 * k), 32'h0, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, NO, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("pre_rst_count", sq.sq_count, 3);
    chk("pre_rst_req", sq.mem_req, 1);
    chk("pre_rst_addr", sq.mem_addr, 32'h200);
    #1 rst_n = 1'b0;
    #1;
    chk("async_req", sq.mem_req, 0);
    chk("async_empty", sq.sq_empty, 1);
    chk("async_count", sq.sq_count, 0);
    chk("async_ready", sq.st_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    drive(1'b0, NO, 32'h0, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("post_rst_count", sq.sq_count, 0);
    chk("post_rst_req", sq.mem_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
